// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, flag bit positions
// and issue sequencer state encodings.
package cpu_pkg;

   localparam int AW = 3;
   localparam int DW = 8;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LSL = 3'd5;
   localparam logic [2:0] OP_LSR = 3'd6;
   localparam logic [2:0] OP_ASR = 3'd7;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   // The ALU never drives its carry bit, so the
   // architectural C is always written as zero.
   function automatic logic [3:0] arch_flags(
      input logic [3:0] f
   );
      return {f[FLAG_Z], f[FLAG_N],
              f[FLAG_C] & 1'b0, f[FLAG_V]};
   endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: one write port, three
// combinational read ports, R0 hardwired to zero.
module regfile
   import cpu_pkg::*;
#(
   parameter int NREGS = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] rs_addr,
   output logic [DW-1:0] rs_data,
   input  logic [AW-1:0] rt_addr,
   output logic [DW-1:0] rt_data,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
);

   logic [DW-1:0] mem_q [NREGS];
   logic [DW-1:0] mem_d [NREGS];

   // Next register contents; R0 forced to zero.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
      mem_d[0] = '0;
   end

   // Register storage, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rs_data  = mem_q[rs_addr];
   assign rt_data  = mem_q[rt_addr];
   assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand issue and writeback sequencer for the 8-bit ALU.
// Accept -> EXEC -> WB, with result bypass on accept in WB.
module alu_issue
   import cpu_pkg::*;
#(
   parameter int NREGS = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [AW-1:0] in_rd,
   input  logic [AW-1:0] in_rs,
   input  logic [AW-1:0] in_rt,
   input  logic [DW-1:0] in_imm,
   input  logic          in_use_imm,
   input  logic [2:0]    in_shamt,
   input  logic          in_setf,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_op,
   output logic [2:0]    alu_shamt,
   input  logic [DW-1:0] alu_out,
   input  logic [3:0]    alu_flags,
   output logic [3:0]    flags,
   output logic          done,
   output logic [AW-1:0] done_rd,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
);

   state_e        state_q, state_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [2:0]    op_q, op_d;
   logic [2:0]    shamt_q, shamt_d;
   logic [AW-1:0] rd_q, rd_d;
   logic          setf_q, setf_d;
   logic [3:0]    flags_q, flags_d;

   logic [DW-1:0] rs_data;
   logic [DW-1:0] rt_data;
   logic          accept;
   logic          wb;
   logic          wb_hit;
   logic          byp_a;
   logic          byp_b;
   logic [DW-1:0] opnd_a;
   logic [DW-1:0] opnd_b;

   regfile #(
      .NREGS(NREGS)
   ) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wb),
      .waddr   (rd_q),
      .wdata   (alu_out),
      .rs_addr (in_rs),
      .rs_data (rs_data),
      .rt_addr (in_rt),
      .rt_data (rt_data),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   assign wb       = (state_q == ST_WB);
   assign in_ready = rst_n & (state_q != ST_EXEC);
   assign accept   = in_valid & in_ready;

   // Forward the in-flight result to a dependent instruction
   // accepted while that result is being written back.
   always_comb begin
      wb_hit = wb && (rd_q != '0);
      byp_a  = wb_hit && (in_rs == rd_q);
      byp_b  = wb_hit && !in_use_imm && (in_rt == rd_q);
      opnd_a = byp_a ? alu_out : rs_data;
      if (in_use_imm) begin
         opnd_b = in_imm;
      end else if (byp_b) begin
         opnd_b = alu_out;
      end else begin
         opnd_b = rt_data;
      end
   end

   // Sequencer next state, operand capture, flag update.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      shamt_d = shamt_q;
      rd_d    = rd_q;
      setf_d  = setf_q;
      flags_d = flags_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_WB;
         end
         ST_WB: begin
            state_d = accept ? ST_EXEC : ST_IDLE;
            if (setf_q) flags_d = arch_flags(alu_flags);
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (accept) begin
         a_d     = opnd_a;
         b_d     = opnd_b;
         op_d    = in_op;
         shamt_d = in_shamt;
         rd_d    = in_rd;
         setf_d  = in_setf;
      end
   end

   // State and operand registers; reset abandons any
   // instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         shamt_q <= '0;
         rd_q    <= '0;
         setf_q  <= 1'b0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         shamt_q <= shamt_d;
         rd_q    <= rd_d;
         setf_q  <= setf_d;
         flags_q <= flags_d;
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign alu_shamt = shamt_q;
   assign flags     = flags_q;
   assign done      = wb;
   assign done_rd   = rd_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small registered
// ALU model driving alu_out/alu_flags.
module tb_alu_issue;
   import cpu_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [2:0] in_rd;
   logic [2:0] in_rs;
   logic [2:0] in_rt;
   logic [7:0] in_imm;
   logic       in_use_imm;
   logic [2:0] in_shamt;
   logic       in_setf;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_op;
   logic [2:0] alu_shamt;
   logic [7:0] alu_out;
   logic [3:0] alu_flags;
   logic [3:0] flags;
   logic       done;
   logic [2:0] done_rd;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;

   int total;
   int bad;
   int done_cnt;

   alu_issue #(
      .NREGS(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_imm    (in_imm),
      .in_use_imm(in_use_imm),
      .in_shamt  (in_shamt),
      .in_setf   (in_setf),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_shamt (alu_shamt),
      .alu_out   (alu_out),
      .alu_flags (alu_flags),
      .flags     (flags),
      .done      (done),
      .done_rd   (done_rd),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: registered result, V = carry/borrow out,
   // C bit driven high to show it gets masked.
   always @(posedge clk) begin
      logic [8:0] r;
      case (alu_op)
         OP_ADD:  r = {1'b0, alu_a} + {1'b0, alu_b};
         OP_SUB:  r = {1'b0, alu_a} - {1'b0, alu_b};
         OP_LSL:  r = {1'b0, alu_a << alu_shamt};
         default: r = '0;
      endcase
      alu_out   <= r[7:0];
      alu_flags <= {r[7:0] == 8'h00, r[7], 1'b1, r[8]};
   end

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op,
                        input logic [2:0] rd,
                        input logic [2:0] rs,
                        input logic [2:0] rt,
                        input logic [7:0] imm,
                        input logic       ui,
                        input logic [2:0] sh,
                        input logic       sf);
      in_op      = op;
      in_rd      = rd;
      in_rs      = rs;
      in_rt      = rt;
      in_imm     = imm;
      in_use_imm = ui;
      in_shamt   = sh;
      in_setf    = sf;
      in_valid   = 1'b1;
   endtask

   task automatic rd_chk(input string tag,
                         input logic [2:0] a,
                         input logic [7:0] exp);
      dbg_addr = a;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      done_cnt   = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_op      = '0;
      in_rd      = '0;
      in_rs      = '0;
      in_rt      = '0;
      in_imm     = '0;
      in_use_imm = 1'b0;
      in_shamt   = '0;
      in_setf    = 1'b0;
      dbg_addr   = '0;
      repeat (3) step();
      chk("rdy_in_reset", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_rdy", in_ready, 1);
      chk("rst_flags", flags, 0);
      chk("rst_a", alu_a, 0);
      chk("rst_b", alu_b, 0);
      chk("rst_op", alu_op, 0);
      chk("rst_sh", alu_shamt, 0);
      chk("rst_done", done, 0);
      chk("rst_done_rd", done_rd, 0);
      rd_chk("rst_r1", 3'd1, 8'h00);

      // ADD r1 <- r0 + 5, setf
      drive(OP_ADD, 3'd1, 3'd0, 3'd0, 8'h05, 1, 0, 1);
      step();
      in_valid = 1'b0;
      chk("t1_a", alu_a, 8'h00);
      chk("t1_b", alu_b, 8'h05);
      chk("t1_op", alu_op, OP_ADD);
      chk("t1_rdy_exec", in_ready, 0);
      chk("t1_nodone", done, 0);
      step();
      chk("t1_done", done, 1);
      chk("t1_done_rd", done_rd, 1);
      chk("t1_rdy_wb", in_ready, 1);
      step();
      chk("t1_done_end", done, 0);
      rd_chk("t1_r1", 3'd1, 8'h05);
      chk("t1_flags", flags, 4'b0000);

      // ADD r2 <- r1 + 0xFB, setf: wraps to zero
      drive(OP_ADD, 3'd2, 3'd1, 3'd0, 8'hFB, 1, 0, 1);
      step();
      in_valid = 1'b0;
      chk("t2_a", alu_a, 8'h05);
      chk("t2_b", alu_b, 8'hFB);
      step();
      chk("t2_done_rd", done_rd, 2);
      step();
      rd_chk("t2_r2", 3'd2, 8'h00);
      chk("t2_flags", flags, 4'b1001);
      chk("t2_done_cnt", done_cnt, 2);

      // Back-to-back with bypass on rt
      drive(OP_ADD, 3'd1, 3'd0, 3'd0, 8'h10, 1, 0, 0);
      step();
      in_valid = 1'b0;
      step();
      step();
      drive(OP_ADD, 3'd2, 3'd0, 3'd0, 8'h01, 1, 0, 0);
      chk("b2b_rdy0", in_ready, 1);
      step();
      chk("b2b_rdy1", in_ready, 0);
      drive(OP_SUB, 3'd3, 3'd1, 3'd2, 8'h00, 0, 0, 0);
      step();
      chk("b2b_rdy2", in_ready, 1);
      chk("b2b_done_rd2", done_rd, 2);
      step();
      in_valid = 1'b0;
      chk("b2b_rdy3", in_ready, 0);
      chk("b2b_a", alu_a, 8'h10);
      chk("b2b_b_bypass", alu_b, 8'h01);
      chk("b2b_op", alu_op, OP_SUB);
      step();
      chk("b2b_done_rd3", done_rd, 3);
      step();
      rd_chk("b2b_r3", 3'd3, 8'h0F);
      rd_chk("b2b_r2", 3'd2, 8'h01);
      chk("b2b_flags", flags, 4'b1001);

      // Write to R0 is discarded but still completes
      drive(OP_ADD, 3'd0, 3'd0, 3'd0, 8'hAA, 1, 0, 0);
      step();
      in_valid = 1'b0;
      step();
      chk("r0_done", done, 1);
      chk("r0_done_rd", done_rd, 0);
      chk("r0_alu_out", alu_out, 8'hAA);
      step();
      rd_chk("r0_read", 3'd0, 8'h00);

      // LSL r4 <- r1(0x81) << 1, no setf
      drive(OP_ADD, 3'd1, 3'd0, 3'd0, 8'h81, 1, 0, 0);
      step();
      in_valid = 1'b0;
      step();
      step();
      drive(OP_LSL, 3'd4, 3'd1, 3'd0, 8'h00, 0, 3'd1, 0);
      step();
      in_valid = 1'b0;
      chk("lsl_a", alu_a, 8'h81);
      chk("lsl_sh", alu_shamt, 1);
      step();
      step();
      rd_chk("lsl_r4", 3'd4, 8'h02);
      chk("lsl_flags", flags, 4'b1001);
      chk("pre_rst_cnt", done_cnt, 8);

      // Reset mid-EXEC abandons the write to r5
      drive(OP_ADD, 3'd5, 3'd0, 3'd0, 8'h33, 1, 0, 1);
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rdy", in_ready, 0);
      chk("mid_rst_done", done, 0);
      step();
      chk("mid_rst_done2", done, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_done", done, 0);
      step();
      chk("post_rst_done2", done, 0);
      rd_chk("post_rst_r5", 3'd5, 8'h00);
      rd_chk("post_rst_r1", 3'd1, 8'h00);
      chk("post_rst_cnt", done_cnt, 8);
      chk("post_rst_flags", flags, 0);

      // Next instruction after reset runs normally
      drive(OP_ADD, 3'd6, 3'd0, 3'd0, 8'h84, 1, 0, 1);
      step();
      in_valid = 1'b0;
      step();
      chk("r6_done_rd", done_rd, 6);
      step();
      rd_chk("r6_val", 3'd6, 8'h84);
      chk("r6_flags", flags, 4'b0100);

      // Idle after WB: ready stays up, no more done
      for (int i = 0; i < 4; i++) begin
         chk("idle_rdy", in_ready, 1);
         chk("idle_done", done, 0);
         step();
      end
      chk("idle_hold_b", alu_b, 8'h84);
      chk("final_cnt", done_cnt, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
